// File: rtl/corr_window_engine.sv
// Template/frame cross-correlation engine: walks a TW x TH window from the latched
// origin and returns the saturating sum of pixel products with fixed latency.
`default_nettype none
module corr_window_engine #(
  parameter int H_RES   = 640,
  parameter int V_RES   = 480,
  parameter int TW      = 16,
  parameter int TH      = 16,
  parameter int MEM_LAT = 2,
  parameter int ADDR_W  = 19,
  parameter int TADDR_W = 8
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic               iStart,
  input  logic [12:0]        iX,
  input  logic [12:0]        iY,
  output logic               oBusy,
  output logic               oCorrFinished,
  output logic [31:0]        oCurrentCorr,
  output logic [ADDR_W-1:0]  oFrameAddr,
  output logic               oFrameRd,
  input  logic [7:0]         iFrameData,
  output logic [TADDR_W-1:0] oTmplAddr,
  input  logic [7:0]         iTmplData
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t               state, state_nxt;
  logic [12:0]          org_x, org_y, tx, ty;
  logic [3:0]           drain_cnt;
  logic [MEM_LAT-1:0]   vld_pipe;
  logic [15:0]          prod;
  logic [31:0]          acc;
  logic [32:0]          acc_sum;
  logic [13:0]          cx, cy;
  logic [31:0]          faddr, taddr;
  logic                 in_frame, last_slot, drain_done, start_ok;

  always_comb begin
    cx         = {1'b0, org_x} + {1'b0, tx};
    cy         = {1'b0, org_y} + {1'b0, ty};
    in_frame   = (cx < 14'(H_RES)) && (cy < 14'(V_RES));
    faddr      = 32'(cy) * 32'(H_RES) + 32'(cx);
    taddr      = 32'(ty) * 32'(TW) + 32'(tx);
    last_slot  = (tx == 13'(TW - 1)) && (ty == 13'(TH - 1));
    // Product of the last slot reaches the accumulator MEM_LAT+2 cycles after issue.
    drain_done = (drain_cnt == 4'(MEM_LAT + 1));
    acc_sum    = {1'b0, acc} + {17'b0, prod};
  end

  always_ff @(posedge iCLK) begin
    if (iRST) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    oBusy         = 1'b0;
    oCorrFinished = 1'b0;
    oFrameRd      = 1'b0;
    oFrameAddr    = '0;
    oTmplAddr     = '0;
    start_ok      = 1'b0;
    case (state)
      IDLE: begin
        if (iStart) begin
          start_ok  = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        oBusy     = 1'b1;
        oTmplAddr = taddr[TADDR_W-1:0];
        if (in_frame) begin
          oFrameRd   = 1'b1;
          oFrameAddr = faddr[ADDR_W-1:0];
        end
        if (last_slot) state_nxt = DRAIN;
      end
      DRAIN: begin
        oBusy = 1'b1;
        if (drain_done) state_nxt = DONE;
      end
      DONE: begin
        oCorrFinished = 1'b1;
        state_nxt     = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      org_x        <= '0;
      org_y        <= '0;
      tx           <= '0;
      ty           <= '0;
      drain_cnt    <= '0;
      vld_pipe     <= '0;
      prod         <= '0;
      acc          <= '0;
      oCurrentCorr <= '0;
    end else begin
      if (start_ok) begin
        org_x <= iX;
        org_y <= iY;
        tx    <= '0;
        ty    <= '0;
        acc   <= '0;
      end else begin
        acc <= acc_sum[32] ? 32'hFFFF_FFFF : acc_sum[31:0];
      end
      if (state == ISSUE) begin
        if (tx == 13'(TW - 1)) begin
          tx <= '0;
          ty <= ty + 13'd1;
        end else begin
          tx <= tx + 13'd1;
        end
      end
      drain_cnt <= (state == DRAIN) ? drain_cnt + 4'd1 : 4'd0;
      // Masked slots never strobe, so their validity bit zeroes the product.
      vld_pipe[0] <= oFrameRd;
      for (int i = 1; i < MEM_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
      prod <= vld_pipe[MEM_LAT-1] ? ({8'b0, iFrameData} * {8'b0, iTmplData}) : 16'd0;
      if (state == DRAIN && drain_done) oCurrentCorr <= acc;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_corr_window_engine.sv
// Directed and randomized checks of corr_window_engine against a loop-based reference.
`default_nettype none
module tb_corr_window_engine;
  localparam int H  = 640;
  localparam int V  = 480;
  localparam int TW = 16;
  localparam int TH = 16;
  localparam int N  = TW * TH;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [12:0] x_in = '0, y_in = '0;
  logic        busy, fin, frd;
  logic [31:0] corr;
  logic [18:0] faddr;
  logic [7:0]  taddr;
  logic [7:0]  fdata, tdata;
  logic [7:0]  fd1, fd2, td1, td2;

  logic [7:0]  frame [H*V];
  logic [7:0]  tmpl  [N];

  int checks = 0;
  int errors = 0;
  longint prev_corr = 0;

  corr_window_engine dut (
    .iCLK(clk), .iRST(rst), .iStart(start), .iX(x_in), .iY(y_in),
    .oBusy(busy), .oCorrFinished(fin), .oCurrentCorr(corr),
    .oFrameAddr(faddr), .oFrameRd(frd), .iFrameData(fdata),
    .oTmplAddr(taddr), .iTmplData(tdata)
  );

  always #10 clk = ~clk;

  // Both memories: address sampled at an edge, data visible two cycles later.
  always @(posedge clk) begin
    fd1 <= (int'(faddr) < H*V) ? frame[int'(faddr)] : 8'd0;
    fd2 <= fd1;
    td1 <= tmpl[int'(taddr)];
    td2 <= td1;
  end
  assign fdata = fd2;
  assign tdata = td2;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic fill(input int fv, input int tv, input bit rnd);
    for (int i = 0; i < H*V; i++) frame[i] = rnd ? 8'($urandom) : 8'(fv);
    for (int i = 0; i < N; i++)   tmpl[i]  = rnd ? 8'($urandom) : 8'(tv);
  endtask

  function automatic void ref_model(input int x, input int y, output longint score,
                                    output int nstr, output int first, output int last);
    score = 0; nstr = 0; first = -1; last = -1;
    for (int ty = 0; ty < TH; ty++)
      for (int tx = 0; tx < TW; tx++)
        if (x + tx < H && y + ty < V) begin
          int a;
          a = (y + ty) * H + x + tx;
          score += longint'(frame[a]) * longint'(tmpl[ty*TW + tx]);
          nstr++;
          if (first < 0) first = a;
          last = a;
        end
    if (score > 64'hFFFF_FFFF) score = 64'hFFFF_FFFF;
  endfunction

  task automatic run_window(input int x, input int y, input int ign_a, input int ign_b,
                            input bit do_rst);
    longint exp_score;
    int exp_str, exp_first, exp_last;
    int strobes, busy_cnt, lat, first, last;
    bit done;
    ref_model(x, y, exp_score, exp_str, exp_first, exp_last);
    @(posedge clk); #1;
    check("idle_c0", {busy, fin, frd}, 0);
    start = 1'b1; x_in = 13'(x); y_in = 13'(y);
    strobes = 0; busy_cnt = 0; lat = 0; first = -1; last = -1; done = 0;
    for (int c = 1; c <= N + 20 && !done; c++) begin
      @(posedge clk); #1;
      start = (c == ign_a || c == ign_b);
      if (start) begin x_in = 13'($urandom); y_in = 13'($urandom); end
      if (c == 1) check("hold_prev", corr, prev_corr);
      if (frd) begin
        strobes++;
        if (first < 0) first = int'(faddr);
        last = int'(faddr);
      end
      if (busy) busy_cnt++;
      if (fin) begin lat = c; done = 1; end
      if (do_rst && c == 100) begin rst = 1'b1; done = 1; end
    end
    if (do_rst) begin
      @(posedge clk); #1;
      check("rst_no_fin", lat, 0);
      check("rst_outs", {busy, fin, frd, faddr, taddr}, 0);
      check("rst_corr", corr, 0);
      rst = 1'b0;
      prev_corr = 0;
    end else begin
      check("latency", lat, N + 5);
      check("score", corr, exp_score);
      check("strobes", strobes, exp_str);
      check("busy_cycles", busy_cnt, N + 4);
      if (exp_str > 0) begin
        check("first_addr", first, exp_first);
        check("last_addr", last, exp_last);
      end
      prev_corr = exp_score;
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_fin", fin, 0);
    check("rst_corr0", corr, 0);
    check("rst_rd", frd, 0);
    check("rst_faddr", faddr, 0);
    check("rst_taddr", taddr, 0);
    rst = 1'b0;

    fill(10, 20, 0);
    run_window(0, 0, -1, -1, 0);
    check("score_const", corr, 51200);
    run_window(632, 0, -1, -1, 0);
    check("score_right", corr, 25600);
    run_window(632, 472, -1, -1, 0);
    check("score_corner", corr, 12800);

    fill(255, 255, 0);
    run_window(100, 50, -1, -1, 0);
    check("score_max", corr, 16646400);

    // Starts during busy and DONE are ignored; back-to-back start is accepted.
    fill(10, 20, 0);
    run_window(0, 0, 50, 261, 0);
    run_window(5, 5, -1, -1, 0);

    fill(0, 0, 1);
    run_window(300, 200, -1, -1, 1);
    run_window(300, 200, -1, -1, 0);
    run_window(700, 10, -1, -1, 0);
    check("score_outside", corr, 0);

    for (int k = 0; k < 6; k++) begin
      int rx, ry;
      rx = (k < 3) ? int'($urandom_range(H - 20, H + 4)) : int'($urandom_range(0, H - 1));
      ry = (k % 2 == 0) ? int'($urandom_range(V - 20, V - 1)) : int'($urandom_range(0, V - 1));
      run_window(rx, ry, -1, -1, 0);
    end

    start = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/corr_window_engine.md
Name: corr_window_engine

Overview:
- Computes the cross-correlation score between a stored template and a captured frame at a requested origin (iX, iY).
- Sits directly upstream of the search controller. It consumes the controller's scan coordinates and returns a done pulse plus a 32-bit score for each coordinate.
- Reads pixels from the frame buffer and the template RAM, both with fixed read latency.
- Score = sum of products of 8-bit pixel pairs over a TW x TH window.

Parameters:
- H_RES, 640: frame width in pixels.
- V_RES, 480: frame height in pixels.
- TW, 16: template width.
- TH, 16: template height.
- MEM_LAT, 2: read latency (cycles) of both memories, address to data.
- ADDR_W, 19: frame-buffer address width.
- TADDR_W, 8: template address width.

Ports:
- iCLK  in  1  system clock (50 MHz); single clock domain.
- iRST  in  1  synchronous, active-high reset.
- iStart  in  1  single-cycle request to correlate at (iX, iY).
- iX  in  13  window origin column.
- iY  in  13  window origin row.
- oBusy  out  1  high from the cycle after start acceptance until the cycle oCorrFinished is asserted.
- oCorrFinished  out  1  one-cycle pulse; oCurrentCorr is valid in this cycle.
- oCurrentCorr  out  32  correlation score.
- oFrameAddr  out  ADDR_W  frame read address = y*H_RES + x.
- oFrameRd  out  1  frame read strobe.
- iFrameData  in  8  frame pixel, valid MEM_LAT cycles after the strobe.
- oTmplAddr  out  TADDR_W  template address = ty*TW + tx.
- iTmplData  in  8  template pixel, valid MEM_LAT cycles after the address.

Behaviour:
- Reset values: oBusy=0, oCorrFinished=0, oCurrentCorr=0, oFrameRd=0, oFrameAddr=0, oTmplAddr=0. FSM enters IDLE and the accumulator clears.
- FSM states: IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
- IDLE:
  - iStart=1 latches iX and iY (call this cycle 0).
  - Goes to ISSUE.
- ISSUE:
  - Lasts exactly N = TW*TH cycles, cycles 1..N.
  - One window pixel per cycle in raster order: tx=0..TW-1 inner loop, ty=0..TH-1 outer loop.
  - oTmplAddr is driven every cycle.
  - If (X+tx) < H_RES and (Y+ty) < V_RES: oFrameRd=1 and oFrameAddr is driven.
  - Otherwise: oFrameRd=0 and the slot's product is forced to 0.
  - Slot validity travels with the data through a MEM_LAT-deep shift register.
- Pipeline:
  - Data returns MEM_LAT cycles after issue.
  - The 8x8 -> 16-bit product is registered 1 cycle later.
  - The accumulator adds the product 1 cycle after that.
- DRAIN: waits for the final product to be accumulated.
- DONE:
  - oCorrFinished=1 for exactly one cycle, at cycle N+MEM_LAT+3, with oCurrentCorr holding the final sum.
  - Returns to IDLE on the next cycle.
- Latency: start-to-finished is exactly N+MEM_LAT+3 cycles.
- oCurrentCorr holds its last result until the next oCorrFinished. The internal accumulator clears on start acceptance.
- Arithmetic: unsigned. The accumulator saturates at 0xFFFFFFFF and never wraps. Saturation is unreachable with the default parameters (max 255*255*256 = 16,646,400).
- iStart while oBusy=1 or in DONE is ignored: no queuing, no change of the latched coordinates.
- iStart in the cycle after DONE (back in IDLE) is accepted normally. The minimum start-to-start spacing is therefore N+MEM_LAT+4 cycles.
- Reset mid-operation:
  - Returns to IDLE on the next edge.
  - No oCorrFinished pulse for the aborted window.
  - oCurrentCorr = 0; the in-flight pipeline is discarded.
- Origin fully outside the frame (iX >= H_RES or iY >= V_RES): no frame reads are issued. Timing is unchanged and the result is 0.
- iX, iY and iStart are sampled only in IDLE; later changes to them have no effect.

Test Plan:
- Frame all 10, template all 20, start at (0,0) in cycle 0 -> oCorrFinished at cycle 261 exactly, oCurrentCorr=51200, oBusy high cycles 1..260, 256 oFrameRd strobes.
- Same memory contents, start at (632,0) -> 128 strobes, right 8 columns masked, oCurrentCorr=25600; start at (632,472) -> 64 strobes, oCurrentCorr=12800.
- Frame and template all 255, start at (100,50) -> oCurrentCorr=16646400; first oFrameAddr=32100, last oFrameAddr=41715.
- iStart pulsed at cycles 50 and 261 during a run started at cycle 0 -> single finished pulse at cycle 261, result for the original coordinates; new start at cycle 262 accepted, finishes at cycle 523.
- iRST asserted at cycle 100 of a run -> no finished pulse, all outputs 0 on the next cycle; a new start after reset produces the correct score with nominal latency.
- Start at (700,10) -> zero strobes, oCorrFinished at cycle 261, oCurrentCorr=0.
